// File: rtl/mux2to1_pkg.sv
// Shared defaults and select encodings for the 2:1 word selector.
// Optional parity is enabled by defining MUX2TO1_PARITY_EN.
package mux2to1_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

  localparam logic SEL_IN1 = 1'b0;
  localparam logic SEL_IN2 = 1'b1;

  typedef logic [DEF_WIDTH-1:0] word_t;

endpackage

// File: rtl/mux2to1_core.sv
// Purely combinational 2:1 select, plus even parity of the result when
// MUX2TO1_PARITY_EN is defined (parity output tied low otherwise).
module mux2to1_core
  import mux2to1_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             ctrl,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             par
);

  // Kept as ?: so an unknown ctrl merges in1/in2 bitwise in simulation.
  assign out = (ctrl == SEL_IN2) ? in2 : in1;

`ifdef MUX2TO1_PARITY_EN
  assign par = ^out;
`else
  assign par = 1'b0;
`endif

endmodule

// File: rtl/mux2to1_32bit.sv
// 2:1 datapath selector: zero-latency combinational output, plus a registered
// copy, captured select, saturating in2-select count and optional parity
// (MUX2TO1_PARITY_EN).
module mux2to1_32bit
  import mux2to1_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  output logic [WIDTH-1:0] out,
  input  logic             ctrl,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic             sel_q,
  output logic [CNT_W-1:0] sel2_cnt,
  output logic             out_par,
  output logic             out_par_q
);

  mux2to1_core #(.WIDTH(WIDTH)) u_core (
    .ctrl (ctrl),
    .in1  (in1),
    .in2  (in2),
    .out  (out),
    .par  (out_par)
  );

  // Valid semantics: a beat is accepted on any non-reset posedge where
  // in_valid is high (no back-pressure). out_valid pulses for exactly one
  // cycle per accepted beat; out_q/sel_q hold their last accepted values.
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             sel_bit_q, sel_bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    data_d    = data_q;
    sel_bit_d = sel_bit_q;
    valid_d   = in_valid;
    cnt_d     = cnt_q;
    if (in_valid) begin
      data_d    = out;
      sel_bit_d = ctrl;
      if (ctrl == SEL_IN2 && cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      sel_bit_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      sel_bit_q <= sel_bit_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef MUX2TO1_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (in_valid) begin
      par_d = out_par;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign out_par_q = par_q;
`else
  assign out_par_q = 1'b0;
`endif

  assign out_q     = data_q;
  assign out_valid = valid_q;
  assign sel_q     = sel_bit_q;
  assign sel2_cnt  = cnt_q;

endmodule

// File: tb/tb_mux2to1_32bit.sv
// Self-checking bench for mux2to1_32bit: directed steps then random beats,
// checked against a behavioural model; a CNT_W=2 instance covers saturation.
module tb_mux2to1_32bit;
  import mux2to1_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        ctrl = 1'b0;
  word_t       in1 = '0;
  word_t       in2 = '0;
  logic        in_valid = 1'b0;

  word_t       out_a, out_q_a;
  logic        out_valid_a, sel_q_a, out_par_a, out_par_q_a;
  logic [15:0] cnt_a;

  word_t       out_b, out_q_b;
  logic        out_valid_b, sel_q_b, out_par_b, out_par_q_b;
  logic [1:0]  cnt_b;

  mux2to1_32bit dut_a (
    .out(out_a), .ctrl(ctrl), .in1(in1), .in2(in2), .clk(clk), .rst(rst),
    .in_valid(in_valid), .out_q(out_q_a), .out_valid(out_valid_a),
    .sel_q(sel_q_a), .sel2_cnt(cnt_a), .out_par(out_par_a), .out_par_q(out_par_q_a)
  );

  mux2to1_32bit #(.WIDTH(32), .CNT_W(2)) dut_b (
    .out(out_b), .ctrl(ctrl), .in1(in1), .in2(in2), .clk(clk), .rst(rst),
    .in_valid(in_valid), .out_q(out_q_b), .out_valid(out_valid_b),
    .sel_q(sel_q_b), .sel2_cnt(cnt_b), .out_par(out_par_b), .out_par_q(out_par_q_b)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] exp_q[$];
  word_t       m_out_q;
  logic        m_valid, m_sel, m_par_q;
  int          m_hits;
  int          total = 0;
  int          passed = 0;

  function automatic logic exp_par(input word_t w);
`ifdef MUX2TO1_PARITY_EN
    return ($countones(w) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int sat(input int n, input int max_v);
    return (n > max_v) ? max_v : n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic c, input word_t a, input word_t b);
    ctrl = c;
    in1  = a;
    in2  = b;
  endtask

  task automatic check_comb();
    word_t sel;
    sel = ctrl ? in2 : in1;
    chk("out_a", out_a, sel);
    chk("out_b", out_b, sel);
    chk("out_par", out_par_a, exp_par(sel));
  endtask

  // Drive one clock cycle's worth of inputs, update model, check after edge.
  task automatic cycle(input logic r, input logic v, input logic c,
                       input word_t a, input word_t b);
    word_t sel;
    word_t e;
    rst      = r;
    in_valid = v;
    set_in(c, a, b);
    #1;
    check_comb();
    sel = c ? b : a;
    if (r) begin
      m_out_q = '0; m_valid = 1'b0; m_sel = 1'b0; m_par_q = 1'b0; m_hits = 0;
      exp_q.delete();
    end else begin
      m_valid = v;
      if (v) begin
        m_out_q = sel;
        m_sel   = c;
        m_par_q = exp_par(sel);
        exp_q.push_back(sel);
        if (c) m_hits++;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid_a, m_valid);
    chk("out_valid_b", out_valid_b, m_valid);
    if (m_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out_q_beat", out_q_a, e);
    end else begin
      chk("out_q_hold", out_q_a, m_out_q);
    end
    chk("out_q_b", out_q_b, m_out_q);
    chk("sel_q", sel_q_a, m_sel);
    chk("out_par_q", out_par_q_a, m_par_q);
    chk("sel2_cnt", cnt_a, sat(m_hits, 65535));
    chk("sel2_cnt_sat", cnt_b, sat(m_hits, 3));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    word_t a, b;
    logic  v, c, r;
    m_out_q = '0; m_valid = 1'b0; m_sel = 1'b0; m_par_q = 1'b0; m_hits = 0;

    // Combinational path, no clock edge involved.
    @(negedge clk);
    set_in(1'b0, 32'hDEADBEEF, 32'h12345678); #1;
    chk("t1_out", out_a, 32'hDEADBEEF);
    set_in(1'b1, 32'hDEADBEEF, 32'h12345678); #1;
    chk("t2_out_sel1", out_a, 32'h12345678);
    ctrl = 1'b0; #1;
    chk("t2_toggle0", out_a, 32'hDEADBEEF);
    ctrl = 1'b1; #1;
    chk("t2_toggle1", out_a, 32'h12345678);
    ctrl = 1'b0; #1;
    chk("t2_toggle2", out_a, 32'hDEADBEEF);
    set_in(1'b1, 32'h0000_0007, 32'h0000_0007); #1;
    chk("t6_par7", out_par_a, exp_par(32'h0000_0007));

    // Reset for two cycles while inputs keep moving (in_valid high too).
    @(posedge clk); #1;
    cycle(1'b1, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222);
    cycle(1'b1, 1'b1, 1'b0, 32'h3333_3333, 32'h4444_4444);
    chk("rst_out_q", out_q_a, 32'h0);
    chk("rst_cnt", cnt_a, 16'h0);

    // First beat after reset, then hold with in_valid low.
    cycle(1'b0, 1'b1, 1'b1, 32'h0F0F_0F0F, 32'hA5A5A5A5);
    chk("t4_out_q", out_q_a, 32'hA5A5A5A5);
    chk("t4_sel_q", sel_q_a, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h5555_5555, 32'h6666_6666);
    chk("t4_hold", out_q_a, 32'hA5A5A5A5);

    // Saturation on the CNT_W=2 instance, then reset beats a valid beat.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, $urandom, $urandom);
    chk("t5_sat3", cnt_b, 2'd3);
    cycle(1'b1, 1'b1, 1'b1, 32'h7777_7777, 32'h8888_8888);
    chk("t5_rst_cnt", cnt_b, 2'd0);

    // in1 == in2: output independent of ctrl, ctrl=1 still counts.
    cycle(1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D);
    chk("eq_cnt", cnt_a, 16'd1);

    // Random beats.
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : word_t'($urandom);
      v = ($urandom_range(0, 3) != 0);
      c = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 39) == 0);
      cycle(r, v, c, a, b);
    end

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
